// File: rtl/leds_pattern_sequencer.sv
// 8-LED pattern sequencer: step-rate divider, per-mode pattern stepping,
// optional auto-advance after REPEATS passes, and a valid/ready mode command port.
module leds_pattern_sequencer #(
  parameter int unsigned DELAY_TICKS = 32'd25_000_000,
  parameter int unsigned REPEATS     = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       auto,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  output logic [1:0] mode,
  output logic [7:0] leds,
  output logic       step_tick
);

  localparam int unsigned DIV_W  = 32;
  localparam int unsigned PASS_W = $clog2(REPEATS + 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_FILL  = 2'd3;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [0:0]        state, state_d;
  logic [1:0]        mode_d;
  logic [7:0]        leds_d;
  logic [DIV_W-1:0]  div, div_d;
  logic [PASS_W-1:0] pass_cnt, pass_d, pass_inc;
  logic              dir, dir_d;
  logic              tick_d, ready_d;
  logic [7:0]        step_leds;
  logic              step_dir;
  logic [1:0]        auto_mode;

  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    case (m)
      MODE_SCAN:  init_pattern = 8'h01;
      MODE_BLINK: init_pattern = 8'hFF;
      MODE_FILL:  init_pattern = 8'h01;
      default:    init_pattern = 8'h00;
    endcase
  endfunction

  // Next pattern and scan direction if a normal step were taken now.
  always_comb begin
    step_leds = leds;
    step_dir  = dir;
    case (mode)
      MODE_SCAN: begin
        if (dir == DIR_UP) begin
          step_leds = {leds[6:0], 1'b0};
          if (step_leds == 8'h80) step_dir = DIR_DOWN;
        end else begin
          step_leds = {1'b0, leds[7:1]};
          if (step_leds == 8'h01) step_dir = DIR_UP;
        end
      end
      MODE_BLINK: step_leds = ~leds;
      MODE_FILL:  step_leds = (leds == 8'hFF) ? 8'h00 : {leds[6:0], 1'b1};
      default:    step_leds = 8'h00;
    endcase
  end

  assign pass_inc  = (pass_cnt == PASS_W'(REPEATS)) ? pass_cnt : pass_cnt + PASS_W'(1);
  assign auto_mode = (mode == MODE_FILL) ? MODE_SCAN : mode + 2'd1;

  // Next-state and registered-output logic; a command always beats a step.
  always_comb begin
    state_d = state;
    mode_d  = mode;
    leds_d  = leds;
    div_d   = div;
    pass_d  = pass_cnt;
    dir_d   = dir;
    tick_d  = 1'b0;
    case (state)
      ST_RUN: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          div_d   = '0;
          pass_d  = '0;
          state_d = ST_LOAD;
        end else if (enable && (mode != MODE_OFF)) begin
          if (div == DIV_W'(DELAY_TICKS - 32'd1)) begin
            div_d  = '0;
            tick_d = 1'b1;
            if (step_leds == init_pattern(mode)) begin
              if (auto && (pass_inc == PASS_W'(REPEATS))) begin
                mode_d = auto_mode;
                leds_d = init_pattern(auto_mode);
                dir_d  = DIR_UP;
                pass_d = '0;
              end else begin
                leds_d = step_leds;
                dir_d  = step_dir;
                pass_d = pass_inc;
              end
            end else begin
              leds_d = step_leds;
              dir_d  = step_dir;
            end
          end else begin
            div_d = div + 32'd1;
          end
        end
      end
      ST_LOAD: begin
        div_d   = '0;
        leds_d  = init_pattern(mode);
        dir_d   = DIR_UP;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      mode      <= MODE_OFF;
      leds      <= 8'h00;
      div       <= '0;
      pass_cnt  <= '0;
      dir       <= DIR_UP;
      step_tick <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_d;
      mode      <= mode_d;
      leds      <= leds_d;
      div       <= div_d;
      pass_cnt  <= pass_d;
      dir       <= dir_d;
      step_tick <= tick_d;
      cmd_ready <= ready_d;
    end
  end

endmodule
